// File: rtl/window_3x3_gen_pkg.sv
// Shared pixel-stream constants for the window generator and the edge/filter stages.
// Parameter defaults and the pixel type live here so every stage agrees on them.
package window_3x3_gen_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int IMG_WIDTH_DEF  = 512;
  localparam int IMG_HEIGHT_DEF = 512;

  typedef logic [DATA_WIDTH_DEF-1:0] pixel_t;
endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// One image line of pixel storage, addressed by column.
// The read is combinational, so a beat sees the old word before its own write lands.
module window_3x3_gen_line_buffer #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];
endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a column-shifting window,
// and a window is emitted one cycle after every beat with row>=2 and col>=2.
module window_3x3_gen
  import window_3x3_gen_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_pixel,
  input  logic                  input_is_valid,
  output logic [DATA_WIDTH-1:0] output_pixel_1,
  output logic [DATA_WIDTH-1:0] output_pixel_2,
  output logic [DATA_WIDTH-1:0] output_pixel_3,
  output logic [DATA_WIDTH-1:0] output_pixel_4,
  output logic [DATA_WIDTH-1:0] output_pixel_5,
  output logic [DATA_WIDTH-1:0] output_pixel_6,
  output logic [DATA_WIDTH-1:0] output_pixel_7,
  output logic [DATA_WIDTH-1:0] output_pixel_8,
  output logic [DATA_WIDTH-1:0] output_pixel_9,
  output logic                  output_is_valid,
  output logic                  frame_done
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] win_q [3][3];
  logic [DATA_WIDTH-1:0] win_d [3][3];
  logic [DATA_WIDTH-1:0] out_q [9];
  logic [DATA_WIDTH-1:0] out_d [9];
  logic                  out_vld_q, out_vld_d;
  logic                  frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0] lb0_rdata, lb1_rdata;
  logic                  lb_wr_en;

  // Reset wins over a coincident beat, so the RAMs must not advance either.
  assign lb_wr_en = input_is_valid & ~rst;

  window_3x3_gen_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH), .AW(CW)) u_lb1 (
    .clk   (clk),
    .wr_en (lb_wr_en),
    .addr  (col_q),
    .wdata (input_pixel),
    .rdata (lb1_rdata)
  );

  window_3x3_gen_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH), .AW(CW)) u_lb0 (
    .clk   (clk),
    .wr_en (lb_wr_en),
    .addr  (col_q),
    .wdata (lb1_rdata),
    .rdata (lb0_rdata)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    out_d        = out_q;
    out_vld_d    = 1'b0;
    frame_done_d = 1'b0;
    if (input_is_valid) begin
      for (int rr = 0; rr < 3; rr++) begin
        win_d[rr][0] = win_q[rr][1];
        win_d[rr][1] = win_q[rr][2];
      end
      win_d[0][2] = lb0_rdata;
      win_d[1][2] = lb1_rdata;
      win_d[2][2] = input_pixel;
      // Two beats into a line the window holds only this line's columns.
      if (row_q >= ROW_TWO && col_q >= COL_TWO) begin
        out_vld_d    = 1'b1;
        frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 3; cc++)
            out_d[rr*3+cc] = win_d[rr][cc];
      end
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      out_vld_q    <= 1'b0;
      frame_done_q <= 1'b0;
      for (int rr = 0; rr < 3; rr++)
        for (int cc = 0; cc < 3; cc++)
          win_q[rr][cc] <= '0;
      for (int k = 0; k < 9; k++) out_q[k] <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_vld_q    <= out_vld_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
      out_q        <= out_d;
    end
  end

  assign output_pixel_1  = out_q[0];
  assign output_pixel_2  = out_q[1];
  assign output_pixel_3  = out_q[2];
  assign output_pixel_4  = out_q[3];
  assign output_pixel_5  = out_q[4];
  assign output_pixel_6  = out_q[5];
  assign output_pixel_7  = out_q[6];
  assign output_pixel_8  = out_q[7];
  assign output_pixel_9  = out_q[8];
  assign output_is_valid = out_vld_q;
  assign frame_done      = frame_done_q;
endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen on a 5x4 image: an image-array reference model checked every
// cycle, plus literal expectations for first/last/wrap windows, gaps, resets and frame seams.
module tb_window_3x3_gen;
  localparam int W = 5;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] input_pixel = 8'h00;
  logic       input_is_valid = 1'b0;
  logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic       output_is_valid, frame_done;

  always #5 clk = ~clk;

  window_3x3_gen #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk             (clk),
    .rst             (rst),
    .input_pixel     (input_pixel),
    .input_is_valid  (input_is_valid),
    .output_pixel_1  (p1),
    .output_pixel_2  (p2),
    .output_pixel_3  (p3),
    .output_pixel_4  (p4),
    .output_pixel_5  (p5),
    .output_pixel_6  (p6),
    .output_pixel_7  (p7),
    .output_pixel_8  (p8),
    .output_pixel_9  (p9),
    .output_is_valid (output_is_valid),
    .frame_done      (frame_done)
  );

  logic [7:0] dut_pix [9];
  assign dut_pix[0] = p1;
  assign dut_pix[1] = p2;
  assign dut_pix[2] = p3;
  assign dut_pix[3] = p4;
  assign dut_pix[4] = p5;
  assign dut_pix[5] = p6;
  assign dut_pix[6] = p7;
  assign dut_pix[7] = p8;
  assign dut_pix[8] = p9;

  typedef struct {
    logic [7:0] p [9];
    logic       fd;
  } win_t;

  win_t cap[$];
  win_t ref1[$];
  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remember the frame as an image and cut windows out of it by coordinates.
  logic [7:0] img [H][W];
  int         mr = 0, mc = 0;
  logic       exp_vld = 1'b0, exp_fd = 1'b0;
  logic [7:0] exp_pix [9];

  always @(posedge clk) begin
    if (rst) begin
      mr      <= 0;
      mc      <= 0;
      exp_vld <= 1'b0;
      exp_fd  <= 1'b0;
      for (int k = 0; k < 9; k++) exp_pix[k] <= 8'h00;
    end else if (input_is_valid) begin
      img[mr][mc] <= input_pixel;
      if (mr >= 2 && mc >= 2) begin
        exp_vld <= 1'b1;
        exp_fd  <= (mr == H-1) && (mc == W-1);
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_pix[i*3+j] <= (i == 2 && j == 2) ? input_pixel : img[mr-2+i][mc-2+j];
      end else begin
        exp_vld <= 1'b0;
        exp_fd  <= 1'b0;
      end
      if (mc == W-1) begin
        mc <= 0;
        mr <= (mr == H-1) ? 0 : mr + 1;
      end else begin
        mc <= mc + 1;
      end
    end else begin
      exp_vld <= 1'b0;
      exp_fd  <= 1'b0;
    end
  end

  // Every cycle: qualifiers match the model and pixels match (held values included).
  always @(negedge clk) begin
    if (chk_en) begin
      win_t w;
      chk("valid", {31'd0, output_is_valid}, {31'd0, exp_vld});
      chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
      for (int k = 0; k < 9; k++) chk($sformatf("pixel_%0d", k+1), {24'd0, dut_pix[k]}, {24'd0, exp_pix[k]});
      if (output_is_valid === 1'b1) begin
        for (int k = 0; k < 9; k++) w.p[k] = dut_pix[k];
        w.fd = frame_done;
        cap.push_back(w);
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] px);
    @(posedge clk);
    #1;
    input_is_valid = v;
    input_pixel    = px;
  endtask

  task automatic flush(input int n);
    repeat (n) drive(1'b0, 8'($urandom));
  endtask

  // mode 0: continuous, 1: one idle after each beat, 2: random 0-3 idles; cb selects checkerboard
  task automatic frame(input logic [7:0] base, input int mode, input logic cb);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        logic [7:0] px;
        px = cb ? (((r + c) % 2 == 1) ? 8'hFF : 8'h00) : 8'(base + 16*r + c);
        drive(1'b1, px);
        if (mode == 1) flush(1);
        if (mode == 2) flush($urandom_range(0, 3));
      end
  endtask

  task automatic same_as_ref(input string name, input int off);
    for (int i = 0; i < 6; i++) begin
      logic ok;
      ok = (cap[off+i].fd === ref1[i].fd);
      for (int k = 0; k < 9; k++) if (cap[off+i].p[k] !== ref1[i].p[k]) ok = 1'b0;
      chk($sformatf("%s_win%0d", name, i), {31'd0, ok}, 32'd1);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    chk("reset_valid", {31'd0, output_is_valid}, 32'd0);
    chk("reset_fd", {31'd0, frame_done}, 32'd0);
    chk("reset_p5", {24'd0, p5}, 32'd0);

    // Continuous frame, plus literal pins for first, wrap and last windows.
    cap.delete();
    frame(8'h00, 0, 1'b0);
    flush(3);
    chk("t1_count", cap.size(), 6);
    chk("t1_first_p1", {24'd0, cap[0].p[0]}, 32'h00);
    chk("t1_first_p5", {24'd0, cap[0].p[4]}, 32'h11);
    chk("t1_first_p9", {24'd0, cap[0].p[8]}, 32'h22);
    chk("t1_first_fd", {31'd0, cap[0].fd}, 32'd0);
    chk("t6_wrap_p1", {24'd0, cap[3].p[0]}, 32'h10);
    chk("t6_wrap_p9", {24'd0, cap[3].p[8]}, 32'h32);
    chk("t1_last_p1", {24'd0, cap[5].p[0]}, 32'h12);
    chk("t1_last_p5", {24'd0, cap[5].p[4]}, 32'h23);
    chk("t1_last_p9", {24'd0, cap[5].p[8]}, 32'h34);
    chk("t1_last_fd", {31'd0, cap[5].fd}, 32'd1);
    ref1 = cap;

    // Gapped input must give the identical window sequence.
    cap.delete();
    frame(8'h00, 1, 1'b0);
    flush(3);
    chk("t2a_count", cap.size(), 6);
    same_as_ref("t2a", 0);
    cap.delete();
    frame(8'h00, 2, 1'b0);
    flush(3);
    chk("t2b_count", cap.size(), 6);
    same_as_ref("t2b", 0);

    // Back-to-back frames: nothing straddles the seam.
    cap.delete();
    frame(8'h00, 0, 1'b0);
    frame(8'h80, 0, 1'b0);
    flush(3);
    chk("t3_count", cap.size(), 12);
    chk("t3_f2_first_p1", {24'd0, cap[6].p[0]}, 32'h80);
    same_as_ref("t3_f1", 0);
    for (int i = 0; i < 12 && i < cap.size(); i++) begin
      logic ok;
      ok = 1'b1;
      for (int k = 0; k < 9; k++) if (cap[i].p[k][7] !== (i >= 6)) ok = 1'b0;
      chk($sformatf("t3_nomix_%0d", i), {31'd0, ok}, 32'd1);
    end

    // Reset after beat (2,3) with a coincident beat, then a fresh frame.
    for (int n = 0; n < 2*W + 4; n++) drive(1'b1, 8'(16*(n / W) + (n % W)));
    @(posedge clk);
    #1;
    rst            = 1'b1;
    input_is_valid = 1'b1;
    input_pixel    = 8'hEE;
    @(posedge clk);
    #1;
    rst            = 1'b0;
    input_is_valid = 1'b0;
    chk("t4_after_rst_valid", {31'd0, output_is_valid}, 32'd0);
    chk("t4_after_rst_p9", {24'd0, p9}, 32'd0);
    cap.delete();
    frame(8'h00, 2, 1'b0);
    flush(3);
    chk("t4_count", cap.size(), 6);
    same_as_ref("t4", 0);

    // Checkerboard of extremes.
    cap.delete();
    frame(8'h00, 0, 1'b1);
    flush(3);
    chk("t5_count", cap.size(), 6);
    for (int i = 0; i < cap.size(); i++) begin
      logic ok;
      ok = 1'b1;
      for (int k = 0; k < 9; k++)
        if (cap[i].p[k] !== ((k % 2 == 0) ? cap[i].p[0] : ~cap[i].p[0])) ok = 1'b0;
      if (cap[i].p[0] !== 8'h00 && cap[i].p[0] !== 8'hFF) ok = 1'b0;
      chk($sformatf("t5_pattern_%0d", i), {31'd0, ok}, 32'd1);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
